// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one owner per bus cycle, rotating priority, no preemption.
// Optional watchdog with abort mask and TIMEOUT_O is built only when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
  parameter int unsigned NUM_OF_MASTER   = 4,
  parameter int unsigned NUM_OF_SEL_BITS = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                       CLK_I,
  input  logic                       RST_N_I,
  input  logic [NUM_OF_MASTER-1:0]   CYC_I,
  input  logic                       ACK_I,
  output logic [NUM_OF_SEL_BITS-1:0] GNT,
  output logic [NUM_OF_MASTER-1:0]   GNT_mux,
  output logic                       CYC,
  output logic                       TIMEOUT_O
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [NUM_OF_SEL_BITS-1:0] LAST_RST = NUM_OF_SEL_BITS'(NUM_OF_MASTER - 1);

  state_t                     state, state_nxt;
  logic [NUM_OF_SEL_BITS-1:0] last, last_nxt, gnt_nxt;
  logic [NUM_OF_MASTER-1:0]   mux_nxt, req;
  logic [NUM_OF_SEL_BITS-1:0] winner, cand;
  logic                       win_found;
  logic                       owner_cyc;
  logic                       expire;

  assign owner_cyc = CYC_I[GNT];
  assign CYC       = (state == GRANT) && owner_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0]          wdog;
  logic [NUM_OF_MASTER-1:0] abort_mask, abort_nxt;

  assign req    = CYC_I & ~abort_mask;
  assign expire = (state == GRANT) && owner_cyc && !ACK_I &&
                  (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // A masked master is released once it abandons its cycle.
  always_comb begin
    abort_nxt = abort_mask & CYC_I;
    if (expire) abort_nxt[GNT] = 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      wdog       <= '0;
      abort_mask <= '0;
      TIMEOUT_O  <= 1'b0;
    end else begin
      wdog       <= (state == GRANT && owner_cyc && !ACK_I) ? wdog + 1'b1 : '0;
      abort_mask <= abort_nxt;
      TIMEOUT_O  <= expire;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_ack;

  assign unused_ack = ACK_I;
  assign req        = CYC_I;
  assign expire     = 1'b0;
  assign TIMEOUT_O  = 1'b0;
`endif

  // First requester at or after last+1, wrapping modulo NUM_OF_MASTER.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_OF_MASTER; i++) begin
      cand = NUM_OF_SEL_BITS'((32'(last) + 32'd1 + i) % NUM_OF_MASTER);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT;
    mux_nxt   = GNT_mux;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt   = winner;
          mux_nxt   = NUM_OF_MASTER'(1) << winner;
          last_nxt  = winner;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!owner_cyc || expire) begin
          mux_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        mux_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        mux_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state   <= IDLE;
      GNT     <= '0;
      GNT_mux <= '0;
      last    <= LAST_RST;
    end else begin
      state   <= state_nxt;
      GNT     <= gnt_nxt;
      GNT_mux <= mux_nxt;
      last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Testbench for wb_rr_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural owner/priority model (watchdog enabled with WB_ARB_TIMEOUT_EN).
module tb_wb_rr_arbiter;

  localparam int N = 4;
  localparam int T = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cyc_i;
  logic       ack;
  logic [1:0] gnt;
  logic [3:0] gnt_mux;
  logic       cyc;
  logic       tmo;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_OF_MASTER(N), .NUM_OF_SEL_BITS(2), .TIMEOUT_CYCLES(T)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .CYC_I(cyc_i), .ACK_I(ack),
    .GNT(gnt), .GNT_mux(gnt_mux), .CYC(cyc), .TIMEOUT_O(tmo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who owns the bus, who is locked out, who went last.
  int m_owner, m_last, m_gnt, m_silent;
  bit m_cool, m_pulse;
  bit m_blk [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gnt = 0; m_silent = 0; m_cool = 0; m_pulse = 0;
    for (int i = 0; i < N; i++) m_blk[i] = 0;
  endtask

  task automatic model_step(input bit r, input logic [3:0] c, input bit a);
    bit keep [N];
    if (!r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) keep[i] = m_blk[i] && c[i];
    m_pulse = 0;
    if (m_owner >= 0) begin
      if (!c[m_owner]) begin
        m_owner = -1; m_cool = 1;
      end else if (TO_EN) begin
        if (a) m_silent = 0;
        else if (m_silent == T - 1) begin
          m_pulse = 1; keep[m_owner] = 1; m_owner = -1; m_cool = 1;
        end else m_silent++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (c[p] && !m_blk[p]) begin
          m_owner = p; m_last = p; m_gnt = p; m_silent = 0;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) m_blk[i] = keep[i];
  endtask

  task automatic drive_check(input bit r, input logic [3:0] c, input bit a);
    logic [3:0] em;
    logic       ec;
    @(negedge clk);
    rst_n = r; cyc_i = c; ack = a;
    #1;
    em = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
    ec = (m_owner >= 0) ? c[m_owner] : 1'b0;
    chk("model_gnt", 32'(gnt), 32'(m_gnt));
    chk("model_gnt_mux", 32'(gnt_mux), 32'(em));
    chk("model_cyc", 32'(cyc), 32'(ec));
    chk("model_timeout", 32'(tmo), 32'(m_pulse));
  endtask

  task automatic advance();
    @(posedge clk);
    model_step(rst_n, cyc_i, ack);
  endtask

  task automatic cycle(input bit r, input logic [3:0] c, input bit a);
    drive_check(r, c, a);
    advance();
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  typedef struct {
    bit         r;
    logic [3:0] c;
    logic [1:0] eg;
    logic [3:0] em;
    bit         ec;
  } vec_t;

  vec_t vec [15];
  int   rr_exp [6];
  int   rr_seen [$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0]  = '{1'b0, 4'hF, 2'd0, 4'h0, 1'b0};
    vec[1]  = '{1'b0, 4'hF, 2'd0, 4'h0, 1'b0};
    vec[2]  = '{1'b0, 4'hF, 2'd0, 4'h0, 1'b0};
    vec[3]  = '{1'b1, 4'hF, 2'd0, 4'h0, 1'b0};
    vec[4]  = '{1'b1, 4'hF, 2'd0, 4'h1, 1'b1};
    vec[5]  = '{1'b1, 4'h0, 2'd0, 4'h1, 1'b0};
    vec[6]  = '{1'b1, 4'h0, 2'd0, 4'h0, 1'b0};
    vec[7]  = '{1'b1, 4'h2, 2'd0, 4'h0, 1'b0};
    vec[8]  = '{1'b1, 4'h2, 2'd1, 4'h2, 1'b1};
    vec[9]  = '{1'b1, 4'h2, 2'd1, 4'h2, 1'b1};
    vec[10] = '{1'b1, 4'h2, 2'd1, 4'h2, 1'b1};
    vec[11] = '{1'b1, 4'h2, 2'd1, 4'h2, 1'b1};
    vec[12] = '{1'b1, 4'h0, 2'd1, 4'h2, 1'b0};
    vec[13] = '{1'b1, 4'h0, 2'd1, 4'h0, 1'b0};
    vec[14] = '{1'b1, 4'h0, 2'd1, 4'h0, 1'b0};
    rr_exp  = '{0, 1, 3, 0, 1, 3};

    rst_n = 1'b0; cyc_i = '0; ack = 1'b0;
    @(posedge clk);
    model_reset();

    // Reset hold and single-master ownership
    for (int i = 0; i < 15; i++) begin
      drive_check(vec[i].r, vec[i].c, 1'b1);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vec[i].eg));
      chk($sformatf("vec%0d_gnt_mux", i), 32'(gnt_mux), 32'(vec[i].em));
      chk($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vec[i].ec));
      chk($sformatf("vec%0d_timeout", i), 32'(tmo), 32'h0);
      advance();
    end

    // Round robin over masters 0, 1, 3 with a one-cycle drop after four owned cycles
    cycle(1'b0, 4'h0, 1'b0);
    begin
      int         hold;
      logic [3:0] v, prev;
      hold = 0; prev = '0;
      for (int it = 0; it < 60 && rr_seen.size() < 6; it++) begin
        v = 4'b1011;
        hold = (m_owner >= 0) ? hold + 1 : 0;
        if (hold == 5) v[m_owner] = 1'b0;
        drive_check(1'b1, v, 1'b1);
        if (gnt_mux != 0 && prev == 0) rr_seen.push_back(onehot_idx(gnt_mux));
        prev = gnt_mux;
        advance();
      end
    end
    chk("rr_grant_count", 32'(rr_seen.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), (i < rr_seen.size()) ? 32'(rr_seen[i]) : 32'hFF, 32'(rr_exp[i]));

    // No preemption: master 0 waits for master 2 to finish
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_check(1'b1, 4'b0101, 1'b1);
      chk("nopre_hold_mux", 32'(gnt_mux), 32'h4);
      chk("nopre_hold_gnt", 32'(gnt), 32'h2);
      advance();
    end
    drive_check(1'b1, 4'b0001, 1'b1);
    chk("nopre_drop_mux", 32'(gnt_mux), 32'h4);
    chk("nopre_drop_cyc", 32'(cyc), 32'h0);
    advance();
    drive_check(1'b1, 4'b0001, 1'b1);
    chk("nopre_release_mux", 32'(gnt_mux), 32'h0);
    advance();
    drive_check(1'b1, 4'b0001, 1'b1);
    chk("nopre_idle_mux", 32'(gnt_mux), 32'h0);
    advance();
    drive_check(1'b1, 4'b0001, 1'b1);
    chk("nopre_handover_mux", 32'(gnt_mux), 32'h1);
    chk("nopre_handover_gnt", 32'(gnt), 32'h0);
    advance();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b1);

    // Watchdog: master 1 never sees ACK
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    for (int i = 0; i < T; i++) begin
      drive_check(1'b1, 4'b0010, 1'b0);
      chk("wd_owned_mux", 32'(gnt_mux), 32'h2);
      chk("wd_owned_timeout", 32'(tmo), 32'h0);
      advance();
    end
    drive_check(1'b1, 4'b0010, 1'b0);
    chk("wd_expire_timeout", 32'(tmo), 32'(TO_EN));
    chk("wd_expire_mux", 32'(gnt_mux), TO_EN ? 32'h0 : 32'h2);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive_check(1'b1, 4'b0010, 1'b0);
      chk("wd_locked_mux", 32'(gnt_mux), TO_EN ? 32'h0 : 32'h2);
      chk("wd_locked_timeout", 32'(tmo), 32'h0);
      advance();
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0);
    drive_check(1'b1, 4'b0010, 1'b0);
    chk("wd_regrant_idle", 32'(gnt_mux), 32'h0);
    advance();
    drive_check(1'b1, 4'b0010, 1'b0);
    chk("wd_regrant_mux", 32'(gnt_mux), 32'h2);
    advance();
    // ACK in grant cycle 7 restarts the count
    for (int k = 2; k <= 6; k++) cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b0010, 1'b1);
    for (int k = 8; k <= 15; k++) begin
      drive_check(1'b1, 4'b0010, 1'b0);
      chk("wd_ack_restart_mux", 32'(gnt_mux), 32'h2);
      chk("wd_ack_restart_timeout", 32'(tmo), 32'h0);
      advance();
    end
    drive_check(1'b1, 4'b0010, 1'b0);
    chk("wd_ack_restart_expire", 32'(tmo), 32'(TO_EN));
    advance();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0);

    // Randomized traffic with sticky requests and sparse resets
    cycle(1'b0, 4'h0, 1'b0);
    begin
      logic [3:0] c;
      bit         a, r;
      c = '0;
      for (int it = 0; it < 3000; it++) begin
        for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) c[b] = ~c[b];
        a = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 199) != 0);
        cycle(r, c, a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
